r16_rom_delay_line: RTL and testbench

- Parametrised, stallable delay line for twiddle/ROM data feeding the radix-16 FFT butterfly datapath.
- Carries one P-width channel (ROMD0) and N_SD SD-width channels (ROMD1..N) through a runtime-selectable delay of 1..MAX_DEPTH cycles.
- A valid bit travels with the data, so downstream stages know which outputs are real.
- Also adds stall, synchronous flush and delay-select clamping with an error flag.

---
 rtl/r16_rom_pkg.sv | 33 +++
 rtl/r16_tap_shift.sv | 56 +++++
 rtl/r16_rom_delay_line.sv | 118 +++++++++++
 tb/tb_r16_rom_delay_line.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/r16_rom_pkg.sv
// -----------------------------------------------------------------------------
// r16_rom_pkg
// Shared definitions for the radix-16 ROM/twiddle delay line.
//   - Default channel widths for the P-domain word and the SD channels.
//   - r16_stage_t: stage word layout {vld, d0, dsd} at the default widths.
//   - clamp_dly(): folds a requested delay into the legal range 1..max_dly.
// -----------------------------------------------------------------------------
package r16_rom_pkg;

    localparam int P_WIDTH_DEF  = 64;
    localparam int SD_WIDTH_DEF = 128;
    localparam int N_SD_DEF     = 7;

    // Layout of one delay stage. The valid bit is the MSB so a stage word
    // can be inspected for validity without unpacking the data fields.
    typedef struct packed {
        logic                             vld;
        logic [P_WIDTH_DEF-1:0]           d0;
        logic [N_SD_DEF*SD_WIDTH_DEF-1:0] dsd;
    } r16_stage_t;

    // Zero requests the shortest delay and anything past the end of the
    // chain requests the longest one; legal values pass through unchanged.
    function automatic int clamp_dly(input int sel, input int max_dly);
        if (sel <= 0)
            return 1;
        else if (sel > max_dly)
            return max_dly;
        else
            return sel;
    endfunction

endpackage

// File: rtl/r16_tap_shift.sv
// -----------------------------------------------------------------------------
// r16_tap_shift
// Generic WIDTH x DEPTH shift register with advance-enable, synchronous
// flush and a muxed read tap.
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   en_i        - advance the chain; 0 holds every stage
//   flush_i     - zero every stage on this edge (wins over en_i)
//   din_i       - word shifted into stage 0
//   tap_i       - stage index presented on tap_o (out-of-range reads 0)
//   tap_o       - contents of stage tap_i
// -----------------------------------------------------------------------------
module r16_tap_shift #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7,
    parameter int TW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [TW-1:0]    tap_i,
    output logic [WIDTH-1:0] tap_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = '0;
        end else if (en_i) begin
            stage_d[0] = din_i;
            for (int i = 1; i < DEPTH; i++)
                stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stage_q <= '0;
        else
            stage_q <= stage_d;
    end

    // Compare-based mux rather than a direct index, so a tap value past the
    // chain end reads as zero instead of an undefined element.
    always_comb begin
        tap_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (tap_i == TW'(i))
                tap_o = stage_q[i];
    end

endmodule

// File: rtl/r16_rom_delay_line.sv
// -----------------------------------------------------------------------------
// r16_rom_delay_line
// Stallable, flushable delay line for ROM/twiddle words feeding the radix-16
// butterfly. One P-width channel and N_SD SD-width channels travel together
// with a valid bit through a runtime-selectable delay of 1..MAX_DEPTH cycles.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   en                  - advance enable; 0 freezes all stages and outputs
//   flush               - synchronous clear of stages and outputs (wins over en)
//   dly_wr, dly_sel     - load a new delay (clamped to 1..MAX_DEPTH)
//   vld_in              - input word valid
//   ROMD0_in            - channel 0 data
//   ROMDSD_in           - SD channels, channel k at [k*SD_WIDTH +: SD_WIDTH]
//   ROMD0_Dout          - delayed channel 0
//   ROMDSD_Dout         - delayed SD channels, same packing as input
//   vld_out             - delayed valid
//   cur_dly             - delay currently in effect
//   cfg_err             - sticky: an out-of-range dly_sel was written
// -----------------------------------------------------------------------------
module r16_rom_delay_line
    import r16_rom_pkg::*;
#(
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int SD_WIDTH  = SD_WIDTH_DEF,
    parameter int N_SD      = N_SD_DEF,
    parameter int MAX_DEPTH = 8,
    parameter int DEF_DLY   = 6,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     dly_wr,
    input  logic [DW-1:0]            dly_sel,
    input  logic                     vld_in,
    input  logic [P_WIDTH-1:0]       ROMD0_in,
    input  logic [N_SD*SD_WIDTH-1:0] ROMDSD_in,
    output logic [P_WIDTH-1:0]       ROMD0_Dout,
    output logic [N_SD*SD_WIDTH-1:0] ROMDSD_Dout,
    output logic                     vld_out,
    output logic [DW-1:0]            cur_dly,
    output logic                     cfg_err
);

    // Same field order as r16_stage_t, sized by this instance's parameters.
    typedef struct packed {
        logic                     vld;
        logic [P_WIDTH-1:0]       d0;
        logic [N_SD*SD_WIDTH-1:0] dsd;
    } stage_t;

    localparam int SW = $bits(stage_t);

    stage_t        in_w, tap_w, out_q, out_d;
    logic [DW-1:0] cur_dly_q, cur_dly_d;
    logic          cfg_err_q, cfg_err_d;
    logic [DW-1:0] tap_sel;

    assign in_w = '{vld: vld_in, d0: ROMD0_in, dsd: ROMDSD_in};

    // The output register is itself the last delay stage, so a delay of N
    // reads chain stage N-2. For N=1 this wraps, but the input bypass below
    // is taken instead and the tap value is unused.
    assign tap_sel = cur_dly_q - DW'(2);

    r16_tap_shift #(
        .WIDTH (SW),
        .DEPTH (MAX_DEPTH - 1),
        .TW    (DW)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en),
        .flush_i (flush),
        .din_i   (in_w),
        .tap_i   (tap_sel),
        .tap_o   (tap_w)
    );

    always_comb begin
        out_d = out_q;
        if (flush)
            out_d = '0;
        else if (en)
            out_d = (cur_dly_q == DW'(1)) ? in_w : tap_w;
    end

    // Delay register ignores en/flush: software can retune while stalled.
    always_comb begin
        cur_dly_d = cur_dly_q;
        cfg_err_d = cfg_err_q;
        if (dly_wr) begin
            cur_dly_d = DW'(clamp_dly(int'(dly_sel), MAX_DEPTH));
            if (dly_sel == '0 || int'(dly_sel) > MAX_DEPTH)
                cfg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            cur_dly_q <= DW'(DEF_DLY);
            cfg_err_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            cur_dly_q <= cur_dly_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign ROMD0_Dout  = out_q.d0;
    assign ROMDSD_Dout = out_q.dsd;
    assign vld_out     = out_q.vld;
    assign cur_dly     = cur_dly_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_r16_rom_delay_line.sv
// -----------------------------------------------------------------------------
// tb_r16_rom_delay_line
// Directed bench for r16_rom_delay_line at default parameters: default delay,
// delay sweep, stall, flush, clamp/error flag and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_r16_rom_delay_line;

    localparam int PW  = 64;
    localparam int SW  = 128;
    localparam int NSD = 7;
    localparam int DW  = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               flush = 1'b0;
    logic               dly_wr = 1'b0;
    logic [DW-1:0]      dly_sel = '0;
    logic               vld_in = 1'b0;
    logic [PW-1:0]      ROMD0_in = '0;
    logic [NSD*SW-1:0]  ROMDSD_in = '0;
    logic [PW-1:0]      ROMD0_Dout;
    logic [NSD*SW-1:0]  ROMDSD_Dout;
    logic               vld_out;
    logic [DW-1:0]      cur_dly;
    logic               cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    r16_rom_delay_line dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .flush       (flush),
        .dly_wr      (dly_wr),
        .dly_sel     (dly_sel),
        .vld_in      (vld_in),
        .ROMD0_in    (ROMD0_in),
        .ROMDSD_in   (ROMDSD_in),
        .ROMD0_Dout  (ROMD0_Dout),
        .ROMDSD_Dout (ROMDSD_Dout),
        .vld_out     (vld_out),
        .cur_dly     (cur_dly),
        .cfg_err     (cfg_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SD channel 3 carries {k, ~k} for valid words and zero otherwise.
    task automatic drive(input logic v, input logic [63:0] k);
        vld_in    = v;
        ROMD0_in  = k;
        ROMDSD_in = '0;
        if (v)
            ROMDSD_in[3*SW +: SW] = {k, ~k};
    endtask

    task automatic set_dly(input int n);
        flush   = 1'b1;
        dly_wr  = 1'b1;
        dly_sel = DW'(n);
        en      = 1'b1;
        drive(1'b0, 64'd0);
        step();
        flush  = 1'b0;
        dly_wr = 1'b0;
    endtask

    initial begin
        logic [63:0]  k;
        logic [127:0] sd_exp;
        logic         v;
        int           e_cnt;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_vld", vld_out, 0);
        check("rst_d0", ROMD0_Dout, 0);
        check("rst_sd3", ROMDSD_Dout[3*SW +: SW], 0);
        check("rst_cur_dly", cur_dly, 6);
        check("rst_cfg_err", cfg_err, 0);
        #2 rst_n = 1'b1;

        // ---------------- default delay (6) ----------------
        en = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c < 10) drive(1'b1, 64'(c + 1));
            else        drive(1'b0, 64'd0);
            step();
            v      = (c >= 5 && c < 15);
            k      = v ? 64'(c - 4) : 64'd0;
            sd_exp = v ? {k, ~k} : 128'd0;
            check("dflt_vld", vld_out, v);
            check("dflt_d0", ROMD0_Dout, k);
            check("dflt_sd3", ROMDSD_Dout[3*SW +: SW], sd_exp);
        end

        // ---------------- delay sweep 1..8 ----------------
        for (int n = 1; n <= 8; n++) begin
            set_dly(n);
            check("sweep_cur_dly", cur_dly, n);
            drive(1'b1, 64'hA5);
            for (int j = 1; j <= 10; j++) begin
                step();
                if (j == 1) drive(1'b0, 64'd0);
                check("sweep_vld", vld_out, j == n);
                check("sweep_d0", ROMD0_Dout, (j == n) ? 64'hA5 : 64'd0);
            end
            check("sweep_cfg_err", cfg_err, 0);
        end

        // ---------------- stall, delay 4 ----------------
        // e_cnt counts enabled edges; word w is sampled on enabled edge w
        // and must appear after enabled edge w+3, frozen across stalls.
        set_dly(4);
        e_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (c >= 6 && c <= 8) begin
                en = 1'b0;
                drive(1'b1, 64'hEE);
            end else begin
                en = 1'b1;
                if (e_cnt < 8) drive(1'b1, 64'(e_cnt + 1));
                else           drive(1'b0, 64'd0);
            end
            step();
            if (en) e_cnt++;
            v = (e_cnt >= 4 && e_cnt <= 11);
            k = v ? 64'(e_cnt - 3) : 64'd0;
            check("stall_vld", vld_out, v);
            check("stall_d0", ROMD0_Dout, k);
        end
        en = 1'b1;

        // ---------------- flush, delay 6 ----------------
        set_dly(6);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 64'(16 + i));
            step();
        end
        flush = 1'b1;
        drive(1'b1, 64'h99);
        step();
        flush = 1'b0;
        check("flush_vld", vld_out, 0);
        check("flush_d0", ROMD0_Dout, 0);
        check("flush_sd3", ROMDSD_Dout[3*SW +: SW], 0);
        check("flush_cur_dly", cur_dly, 6);
        drive(1'b1, 64'h77);
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 1) drive(1'b0, 64'd0);
            check("flush_post_vld", vld_out, j == 6);
            check("flush_post_d0", ROMD0_Dout, (j == 6) ? 64'h77 : 64'd0);
        end

        // ---------------- clamp and sticky error ----------------
        dly_wr = 1'b1; dly_sel = 4'd0;
        step();
        check("clamp0_cur_dly", cur_dly, 1);
        check("clamp0_cfg_err", cfg_err, 1);
        dly_sel = 4'd15;
        step();
        check("clamp15_cur_dly", cur_dly, 8);
        check("clamp15_cfg_err", cfg_err, 1);
        dly_sel = 4'd3;
        step();
        dly_wr = 1'b0;
        check("clamp3_cur_dly", cur_dly, 3);
        check("clamp3_cfg_err", cfg_err, 1);

        // ---------------- async reset mid-stream (delay 3) ----------------
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(48 + i));
            step();
        end
        check("pre_rst_vld", vld_out, 1);
        check("pre_rst_d0", ROMD0_Dout, 64'd50);
        #3 rst_n = 1'b0;
        #1;
        check("arst_vld", vld_out, 0);
        check("arst_d0", ROMD0_Dout, 0);
        check("arst_sd3", ROMDSD_Dout[3*SW +: SW], 0);
        check("arst_cfg_err", cfg_err, 0);
        check("arst_cur_dly", cur_dly, 6);
        #1 rst_n = 1'b1;
        drive(1'b1, 64'h55);
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 1) drive(1'b0, 64'd0);
            check("post_rst_vld", vld_out, j == 6);
            check("post_rst_d0", ROMD0_Dout, (j == 6) ? 64'h55 : 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
